// File: rtl/axis_beam_splitter.sv
// rtl/axis_beam_splitter.sv - one input stream broadcast to four complex-weighted output streams
module axis_beam_splitter #(
  parameter int DATA_WIDTH   = 128,
  parameter int SAMPLE_WIDTH = 16,
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [WEIGHT_WIDTH-1:0] w0_real,
  input  logic [WEIGHT_WIDTH-1:0] w0_imag,
  input  logic [WEIGHT_WIDTH-1:0] w1_real,
  input  logic [WEIGHT_WIDTH-1:0] w1_imag,
  input  logic [WEIGHT_WIDTH-1:0] w2_real,
  input  logic [WEIGHT_WIDTH-1:0] w2_imag,
  input  logic [WEIGHT_WIDTH-1:0] w3_real,
  input  logic [WEIGHT_WIDTH-1:0] w3_imag,
  input  logic                    weight_load,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m0_axis_tdata,
  output logic                    m0_axis_tvalid,
  output logic                    m0_axis_tlast,
  input  logic                    m0_axis_tready,
  output logic [DATA_WIDTH-1:0]   m1_axis_tdata,
  output logic                    m1_axis_tvalid,
  output logic                    m1_axis_tlast,
  input  logic                    m1_axis_tready,
  output logic [DATA_WIDTH-1:0]   m2_axis_tdata,
  output logic                    m2_axis_tvalid,
  output logic                    m2_axis_tlast,
  input  logic                    m2_axis_tready,
  output logic [DATA_WIDTH-1:0]   m3_axis_tdata,
  output logic                    m3_axis_tvalid,
  output logic                    m3_axis_tlast,
  input  logic                    m3_axis_tready,
  output logic [15:0]             sat_count
);
  localparam int NS    = DATA_WIDTH / (2 * SAMPLE_WIDTH);
  localparam int PW    = SAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int AW    = PW + 1;
  localparam int SHIFT = WEIGHT_WIDTH - 1;
  localparam int RND   = 1 << (WEIGHT_WIDTH - 2);
  localparam int MAXV  = (1 << (SAMPLE_WIDTH - 1)) - 1;
  localparam int MINV  = -(1 << (SAMPLE_WIDTH - 1));
  localparam int CW    = $clog2(8 * NS + 1);
  localparam logic [WEIGHT_WIDTH-1:0] W_ONE = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};

  typedef logic signed [AW-1:0] acc_t;

  // Real part of x*w at full precision: xI*wr - xQ*wi
  function automatic acc_t cmul_re(input logic signed [SAMPLE_WIDTH-1:0] xi, xq,
                                   input logic signed [WEIGHT_WIDTH-1:0] wr, wi);
    logic signed [PW-1:0] pa, pb;
    pa = xi * wr;
    pb = xq * wi;
    return AW'(pa) - AW'(pb);
  endfunction

  // Imaginary part of x*w at full precision: xI*wi + xQ*wr
  function automatic acc_t cmul_im(input logic signed [SAMPLE_WIDTH-1:0] xi, xq,
                                   input logic signed [WEIGHT_WIDTH-1:0] wr, wi);
    logic signed [PW-1:0] pa, pb;
    pa = xi * wi;
    pb = xq * wr;
    return AW'(pa) + AW'(pb);
  endfunction

  // Round half up back to sample scale and clamp; MSB of the result flags a clamp
  function automatic logic [SAMPLE_WIDTH:0] round_sat(input acc_t acc);
    logic signed [AW:0] r;
    r = ((AW+1)'(acc) + (AW+1)'(RND)) >>> SHIFT;
    if (r > (AW+1)'(MAXV))      return {1'b1, SAMPLE_WIDTH'(MAXV)};
    else if (r < (AW+1)'(MINV)) return {1'b1, SAMPLE_WIDTH'(MINV)};
    else                        return {1'b0, r[SAMPLE_WIDTH-1:0]};
  endfunction

  logic [WEIGHT_WIDTH-1:0] stage_re [4];
  logic [WEIGHT_WIDTH-1:0] stage_im [4];
  logic [WEIGHT_WIDTH-1:0] act_re [4];
  logic [WEIGHT_WIDTH-1:0] act_im [4];
  acc_t                    acc_next [4][NS][2];
  acc_t                    s1_acc [4][NS][2];
  logic [DATA_WIDTH-1:0]   data_next [4];
  logic [DATA_WIDTH-1:0]   m_data [4];
  logic [SAMPLE_WIDTH:0]   rs;
  logic [CW-1:0]           sat_inc;
  logic [16:0]             sat_sum;
  logic [3:0]              pending;
  logic [3:0]              m_ready;
  logic                    ready_en, s1_valid, s1_last, s2_last;
  logic                    s_hs, s2_free, s1_xfer;

  assign stage_re[0] = w0_real;
  assign stage_im[0] = w0_imag;
  assign stage_re[1] = w1_real;
  assign stage_im[1] = w1_imag;
  assign stage_re[2] = w2_real;
  assign stage_im[2] = w2_imag;
  assign stage_re[3] = w3_real;
  assign stage_im[3] = w3_imag;

  assign m_ready       = {m3_axis_tready, m2_axis_tready, m1_axis_tready, m0_axis_tready};
  assign s2_free       = ~|(pending & ~m_ready);
  assign s1_xfer       = s1_valid & s2_free;
  assign s_axis_tready = ready_en & (~s1_valid | s1_xfer);
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign sat_sum       = {1'b0, sat_count} + 17'(sat_inc);

  // Full-precision weighted sums of the beat at the input, using the current active weights
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < NS; j++) begin
        acc_next[k][j][0] = cmul_re(s_axis_tdata[2*SAMPLE_WIDTH*j +: SAMPLE_WIDTH],
                                    s_axis_tdata[2*SAMPLE_WIDTH*j+SAMPLE_WIDTH +: SAMPLE_WIDTH],
                                    act_re[k], act_im[k]);
        acc_next[k][j][1] = cmul_im(s_axis_tdata[2*SAMPLE_WIDTH*j +: SAMPLE_WIDTH],
                                    s_axis_tdata[2*SAMPLE_WIDTH*j+SAMPLE_WIDTH +: SAMPLE_WIDTH],
                                    act_re[k], act_im[k]);
      end
    end
  end

  // Round, clamp and repack the S1 sums, counting clamped components
  always_comb begin
    rs      = '0;
    sat_inc = '0;
    for (int k = 0; k < 4; k++) begin
      data_next[k] = '0;
      for (int j = 0; j < NS; j++) begin
        for (int c = 0; c < 2; c++) begin
          rs = round_sat(s1_acc[k][j][c]);
          data_next[k][2*SAMPLE_WIDTH*j + SAMPLE_WIDTH*c +: SAMPLE_WIDTH] = rs[SAMPLE_WIDTH-1:0];
          sat_inc = sat_inc + CW'(rs[SAMPLE_WIDTH]);
        end
      end
    end
  end

  // Active weights: unity after reset, reloaded from the staged inputs on weight_load
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (!resetn) begin
        act_re[k] <= W_ONE;
        act_im[k] <= '0;
      end else if (weight_load) begin
        act_re[k] <= stage_re[k];
        act_im[k] <= stage_im[k];
      end
    end
  end

  // S1: capture products and tlast on an input handshake, hold until S2 takes them
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ready_en <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= s_hs | (s1_valid & ~s1_xfer);
      if (s_hs) begin
        s1_acc  <= acc_next;
        s1_last <= s_axis_tlast;
      end
    end
  end

  // S2: output registers, per-channel pending bits and saturation counter
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pending   <= '0;
      s2_last   <= 1'b0;
      sat_count <= '0;
      for (int k = 0; k < 4; k++) m_data[k] <= '0;
    end else begin
      pending <= s1_xfer ? 4'hF : (pending & ~m_ready);
      if (s1_xfer) begin
        m_data    <= data_next;
        s2_last   <= s1_last;
        sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

  assign m0_axis_tdata  = m_data[0];
  assign m1_axis_tdata  = m_data[1];
  assign m2_axis_tdata  = m_data[2];
  assign m3_axis_tdata  = m_data[3];
  assign m0_axis_tvalid = pending[0];
  assign m1_axis_tvalid = pending[1];
  assign m2_axis_tvalid = pending[2];
  assign m3_axis_tvalid = pending[3];
  assign m0_axis_tlast  = s2_last;
  assign m1_axis_tlast  = s2_last;
  assign m2_axis_tlast  = s2_last;
  assign m3_axis_tlast  = s2_last;

endmodule
